// File: rtl/servo_pwm_gen.sv
// -----------------------------------------------------------------------------
// servo_pwm_gen
//
// Fixed-period servo PWM generator. The requested duty word is clamped to
// [MIN_DUTY, MAX_DUTY] and slew-limited per frame. It is latched only on a
// frame boundary (a "load edge"), so a pulse in progress is never shortened
// or stretched. A one-cycle period_tick marks the first cycle of every frame
// and can serve as the sample strobe for the upstream PID stage.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   en           in   run request (level); sampled at frame boundaries
//   duty_in      in   [17:0] requested high time in clk cycles
//   pwm_out      out  servo pulse (registered)
//   period_tick  out  high for the first cycle of each frame
//   active_duty  out  [17:0] high time of the frame being generated
//   clamped      out  last load saturated duty_in to MIN_DUTY/MAX_DUTY
//   running      out  high while the generator is in RUN
// -----------------------------------------------------------------------------
module servo_pwm_gen #(
    parameter int PERIOD_CNT  = 1000000,
    parameter int MIN_DUTY    = 50000,
    parameter int CENTER_DUTY = 75000,
    parameter int MAX_DUTY    = 100000,
    parameter int SLEW_MAX    = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [17:0] duty_in,
    output logic        pwm_out,
    output logic        period_tick,
    output logic [17:0] active_duty,
    output logic        clamped,
    output logic        running
);

    if (!(MIN_DUTY > 0 && MIN_DUTY <= CENTER_DUTY && CENTER_DUTY <= MAX_DUTY &&
          MAX_DUTY < PERIOD_CNT && PERIOD_CNT <= (1 << 20))) begin : g_param_check
        $fatal(1, "servo_pwm_gen: illegal parameter combination");
    end

    localparam int CNT_W = (PERIOD_CNT > 1) ? $clog2(PERIOD_CNT) : 1;

    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(PERIOD_CNT - 1);
    localparam logic [17:0]        MIN_D    = 18'(MIN_DUTY);
    localparam logic [17:0]        MAX_D    = 18'(MAX_DUTY);
    localparam logic [17:0]        CENTER_D = 18'(CENTER_DUTY);
    localparam logic [17:0]        SLEW_D   = 18'(SLEW_MAX);
    localparam logic signed [18:0] SLEW_S   = 19'(SLEW_MAX);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pwm_q, pwm_d;
    logic               tick_q, tick_d;
    logic               clamped_q, clamped_d;
    logic               running_q, running_d;
    logic [17:0]        duty_q, duty_d;

    logic               load;
    logic               sat_lo, sat_hi;
    logic [17:0]        target;
    logic signed [18:0] diff;
    logic [17:0]        slewed;
    logic [31:0]        cnt_inc;

    // Range clamp and slew limit of the requested duty. Both target and
    // duty_q always lie inside [MIN_DUTY, MAX_DUTY], so the signed 19-bit
    // difference and the +/-SLEW step can never wrap.
    always_comb begin
        sat_lo = (duty_in < MIN_D);
        sat_hi = (duty_in > MAX_D);
        target = sat_lo ? MIN_D : (sat_hi ? MAX_D : duty_in);
        diff   = $signed({1'b0, target}) - $signed({1'b0, duty_q});
        slewed = target;
        if (SLEW_MAX != 0) begin
            if (diff > SLEW_S) begin
                slewed = duty_q + SLEW_D;
            end else if (diff < -SLEW_S) begin
                slewed = duty_q - SLEW_D;
            end
        end
    end

    // Position the next edge will move to; the pulse stays high while that
    // position is still below the active duty.
    assign cnt_inc = 32'(cnt_q) + 32'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pwm_d     = 1'b0;
        tick_d    = 1'b0;
        load      = 1'b0;
        duty_d    = duty_q;
        clamped_d = clamped_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (en) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    pwm_d = (cnt_inc < 32'(duty_q));
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A load starts a new frame: pulse rises on this edge with the new duty.
        if (load) begin
            pwm_d     = 1'b1;
            tick_d    = 1'b1;
            duty_d    = slewed;
            clamped_d = sat_lo | sat_hi;
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pwm_q     <= 1'b0;
            tick_q    <= 1'b0;
            clamped_q <= 1'b0;
            running_q <= 1'b0;
            duty_q    <= CENTER_D;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pwm_q     <= pwm_d;
            tick_q    <= tick_d;
            clamped_q <= clamped_d;
            running_q <= running_d;
            duty_q    <= duty_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;
    assign active_duty = duty_q;
    assign clamped     = clamped_q;
    assign running     = running_q;

endmodule
